// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one 16-bit memory port between a ROM loader, a CPU
// byte port and an RV toggle-handshake word port, with RV anti-starvation and
// an ack timeout that aborts a hung transaction.
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 64,
  parameter int unsigned ACK_TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        loading,
  input  logic        ld_write,
  input  logic [21:0] ld_addr,
  input  logic [7:0]  ld_data,
  output logic        ld_busy,
  input  logic        cpu_read,
  input  logic        cpu_write,
  input  logic [21:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  output logic [7:0]  cpu_din,
  output logic        cpu_done,
  input  logic        rv_req,
  output logic        rv_req_ack,
  input  logic [21:0] rv_addr,
  input  logic        rv_we,
  input  logic [1:0]  rv_ds,
  input  logic [15:0] rv_din,
  output logic [15:0] rv_dout,
  output logic        m_req,
  output logic        m_we,
  output logic [21:0] m_addr,
  output logic [1:0]  m_ds,
  output logic [15:0] m_din,
  input  logic        m_ack,
  input  logic [15:0] m_dout,
  output logic        err
);

  localparam int unsigned SCW = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned TCW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_e;
  typedef enum logic [1:0] {SEL_LD, SEL_CPU, SEL_RV} sel_e;

  state_e state_q, state_d;
  sel_e   sel_q, grant_c;

  logic        ld_v_q, cpu_v_q, rv_v_q;
  logic [21:0] ld_addr_q, cpu_addr_q, rv_addr_q;
  logic [7:0]  ld_data_q, cpu_data_q;
  logic        cpu_we_q, rv_we_q;
  logic [1:0]  rv_ds_q;
  logic [15:0] rv_din_q;

  logic        m_we_q;
  logic [21:0] m_addr_q;
  logic [1:0]  m_ds_q;
  logic [15:0] m_din_q;
  logic [7:0]  cpu_din_q;
  logic        cpu_done_q;
  logic [15:0] rv_dout_q;
  logic        rv_req_ack_q;
  logic        err_q;
  logic [SCW-1:0] starve_q;
  logic [TCW-1:0] wait_q;

  logic any_pend_c, starved_c, wait_last_c, rv_busy_c;
  logic select_c, finish_c, timeout_c;
  logic ld_take_c, cpu_take_c, rv_take_c;
  logic ld_free_c, cpu_free_c, rv_free_c;

  assign any_pend_c  = ld_v_q | cpu_v_q | rv_v_q;
  assign starved_c   = (starve_q == SCW'(STARVE_LIMIT));
  assign wait_last_c = (wait_q == TCW'(ACK_TIMEOUT - 1));
  assign rv_busy_c   = (state_q != ST_IDLE) && (sel_q == SEL_RV);

  // Slot bookkeeping: a slot frees on completion and may refill in that same cycle
  assign ld_free_c  = finish_c && (sel_q == SEL_LD);
  assign cpu_free_c = finish_c && (sel_q == SEL_CPU);
  assign rv_free_c  = finish_c && (sel_q == SEL_RV);
  assign ld_take_c  = ld_write && (!ld_v_q || ld_free_c);
  assign cpu_take_c = (cpu_read || cpu_write) && !loading && (!cpu_v_q || cpu_free_c);
  assign rv_take_c  = (rv_req != rv_req_ack_q) && !rv_v_q;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (any_pend_c) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  if (m_ack || wait_last_c) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Per-state decode: grant choice, memory request strobe, completion/timeout
  always_comb begin
    m_req     = 1'b0;
    select_c  = 1'b0;
    finish_c  = 1'b0;
    timeout_c = 1'b0;
    grant_c   = SEL_RV;
    if (ld_v_q)                  grant_c = SEL_LD;
    else if (rv_v_q && starved_c) grant_c = SEL_RV;
    else if (cpu_v_q)            grant_c = SEL_CPU;
    case (state_q)
      ST_IDLE:  select_c = any_pend_c;
      ST_ISSUE: m_req = 1'b1;
      ST_WAIT: begin
        finish_c  = m_ack || wait_last_c;
        timeout_c = !m_ack && wait_last_c;
      end
      default: ;
    endcase
  end

  // Request slots, memory-port payload, completion results and counters
  always_ff @(posedge clk) begin
    if (reset) begin
      ld_v_q <= 1'b0; cpu_v_q <= 1'b0; rv_v_q <= 1'b0;
      ld_addr_q <= '0; ld_data_q <= '0;
      cpu_addr_q <= '0; cpu_data_q <= '0; cpu_we_q <= 1'b0;
      rv_addr_q <= '0; rv_din_q <= '0; rv_we_q <= 1'b0; rv_ds_q <= '0;
      sel_q <= SEL_LD;
      m_we_q <= 1'b0; m_addr_q <= '0; m_ds_q <= '0; m_din_q <= '0;
      cpu_din_q <= '0; cpu_done_q <= 1'b0; rv_dout_q <= '0;
      rv_req_ack_q <= rv_req;
      err_q <= 1'b0;
      starve_q <= '0;
      wait_q <= '0;
    end else begin
      if (ld_take_c) begin
        ld_v_q <= 1'b1; ld_addr_q <= ld_addr; ld_data_q <= ld_data;
      end else if (ld_free_c) begin
        ld_v_q <= 1'b0;
      end
      if (cpu_take_c) begin
        cpu_v_q <= 1'b1; cpu_we_q <= cpu_write; cpu_addr_q <= cpu_addr; cpu_data_q <= cpu_dout;
      end else if (cpu_free_c) begin
        cpu_v_q <= 1'b0;
      end
      if (rv_take_c) begin
        rv_v_q <= 1'b1; rv_we_q <= rv_we; rv_addr_q <= rv_addr;
        rv_ds_q <= rv_ds; rv_din_q <= rv_din;
      end else if (rv_free_c) begin
        rv_v_q <= 1'b0;
      end

      if (select_c) begin
        sel_q <= grant_c;
        case (grant_c)
          SEL_LD: begin
            m_we_q   <= 1'b1;
            m_addr_q <= 22'(ld_addr_q[21:1]);
            m_ds_q   <= ld_addr_q[0] ? 2'b10 : 2'b01;
            m_din_q  <= {ld_data_q, ld_data_q};
          end
          SEL_CPU: begin
            m_we_q   <= cpu_we_q;
            m_addr_q <= 22'(cpu_addr_q[21:1]);
            m_ds_q   <= cpu_addr_q[0] ? 2'b10 : 2'b01;
            m_din_q  <= {cpu_data_q, cpu_data_q};
          end
          default: begin
            m_we_q   <= rv_we_q;
            m_addr_q <= rv_addr_q;
            m_ds_q   <= rv_ds_q;
            m_din_q  <= rv_din_q;
          end
        endcase
      end

      if (state_q == ST_WAIT && !finish_c) wait_q <= wait_q + TCW'(1);
      else                                 wait_q <= '0;

      if (!rv_v_q || (select_c && grant_c == SEL_RV)) starve_q <= '0;
      else if (!rv_busy_c && !starved_c)              starve_q <= starve_q + SCW'(1);

      cpu_done_q <= cpu_free_c;
      if (cpu_free_c && !cpu_we_q)
        cpu_din_q <= timeout_c ? 8'hFF : (cpu_addr_q[0] ? m_dout[15:8] : m_dout[7:0]);
      if (rv_free_c) begin
        rv_req_ack_q <= ~rv_req_ack_q;
        if (!rv_we_q) rv_dout_q <= timeout_c ? 16'hFFFF : m_dout;
      end
      if (timeout_c) err_q <= 1'b1;
    end
  end

  assign ld_busy    = ld_v_q;
  assign cpu_din    = cpu_din_q;
  assign cpu_done   = cpu_done_q;
  assign rv_req_ack = rv_req_ack_q;
  assign rv_dout    = rv_dout_q;
  assign m_we       = m_we_q;
  assign m_addr     = m_addr_q;
  assign m_ds       = m_ds_q;
  assign m_din      = m_din_q;
  assign err        = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: table vectors for the CPU byte path, randomized mixed
// traffic against a word-memory model, and hand sequences for starvation,
// loading inhibit, timeout and mid-transaction reset.
module tb_mem_port_arbiter;

  localparam int unsigned STARVE = 64;
  localparam int unsigned TMO    = 255;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        loading = 1'b0;
  logic        ld_write = 1'b0;
  logic [21:0] ld_addr = '0;
  logic [7:0]  ld_data = '0;
  logic        ld_busy;
  logic        cpu_read = 1'b0, cpu_write = 1'b0;
  logic [21:0] cpu_addr = '0;
  logic [7:0]  cpu_dout = '0;
  logic [7:0]  cpu_din;
  logic        cpu_done;
  logic        rv_req = 1'b1;
  logic        rv_req_ack;
  logic [21:0] rv_addr = '0;
  logic        rv_we = 1'b0;
  logic [1:0]  rv_ds = '0;
  logic [15:0] rv_din = '0;
  logic [15:0] rv_dout;
  logic        m_req, m_we;
  logic [21:0] m_addr;
  logic [1:0]  m_ds;
  logic [15:0] m_din;
  logic        m_ack = 1'b0;
  logic [15:0] m_dout = '0;
  logic        err;

  mem_port_arbiter #(.STARVE_LIMIT(STARVE), .ACK_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .loading(loading),
    .ld_write(ld_write), .ld_addr(ld_addr), .ld_data(ld_data), .ld_busy(ld_busy),
    .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
    .cpu_din(cpu_din), .cpu_done(cpu_done),
    .rv_req(rv_req), .rv_req_ack(rv_req_ack), .rv_addr(rv_addr), .rv_we(rv_we),
    .rv_ds(rv_ds), .rv_din(rv_din), .rv_dout(rv_dout),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_ds(m_ds), .m_din(m_din),
    .m_ack(m_ack), .m_dout(m_dout), .err(err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [15:0] mem [0:15];

  typedef struct {
    logic        we;
    logic [21:0] addr;
    logic [7:0]  wdata;
    logic [15:0] mdout;
    logic [21:0] exp_maddr;
    logic [1:0]  exp_ds;
    logic [15:0] exp_din;
    logic [7:0]  exp_rd;
  } vec_t;
  vec_t tbl [5];

  task automatic step();
    @(posedge clk); #1; cyc++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_mreq(input string name, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      if (m_req === 1'b1) ok = 1'b1;
      else step();
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL %s: no m_req within %0d cycles", name, budget);
    end
  endtask

  // Memory side: wait for the request, check it, ack after lat WAIT cycles
  task automatic serve(input string name, input logic exp_we, input logic [21:0] exp_addr,
                       input logic [1:0] exp_ds, input logic [15:0] exp_din,
                       input bit chk_din, input int lat, input bit restrobe_cpu);
    bit ok;
    wait_mreq(name, 12, ok);
    if (!ok) return;
    chk({name, " m_we"}, m_we, exp_we);
    chk({name, " m_addr"}, m_addr, exp_addr);
    chk({name, " m_ds"}, m_ds, exp_ds);
    if (chk_din) chk({name, " m_din"}, m_din, exp_din);
    step();
    chk({name, " m_req pulse"}, m_req, 0);
    for (int i = 1; i < lat; i++) step();
    chk({name, " addr held"}, m_addr, exp_addr);
    m_ack  = 1'b1;
    m_dout = mem[exp_addr[3:0]];
    if (exp_we) begin
      if (exp_ds[0]) mem[exp_addr[3:0]][7:0]  = exp_din[7:0];
      if (exp_ds[1]) mem[exp_addr[3:0]][15:8] = exp_din[15:8];
    end
    if (restrobe_cpu) cpu_read = 1'b1;
    step();
    m_ack = 1'b0;
    cpu_read = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit ok;
    int seen;
    tbl[0] = '{1'b0, 22'h000101, 8'h00, 16'hAB12, 22'h000080, 2'b10, 16'h0000, 8'hAB};
    tbl[1] = '{1'b0, 22'h000100, 8'h00, 16'hAB12, 22'h000080, 2'b01, 16'h0000, 8'h12};
    tbl[2] = '{1'b1, 22'h3FFFFF, 8'h5A, 16'h0000, 22'h1FFFFF, 2'b10, 16'h5A5A, 8'h00};
    tbl[3] = '{1'b1, 22'h000000, 8'hC3, 16'h0000, 22'h000000, 2'b01, 16'hC3C3, 8'h00};
    tbl[4] = '{1'b0, 22'h3FFFFE, 8'h00, 16'h00FF, 22'h1FFFFF, 2'b01, 16'h0000, 8'hFF};
    for (int i = 0; i < 16; i++) mem[i] = 16'($urandom);

    // Reset values, with rv_req already high so rv_req_ack must follow it
    step(); step(); step();
    chk("rst m_req", m_req, 0);   chk("rst m_we", m_we, 0);
    chk("rst m_addr", m_addr, 0); chk("rst m_ds", m_ds, 0);
    chk("rst m_din", m_din, 0);   chk("rst cpu_done", cpu_done, 0);
    chk("rst cpu_din", cpu_din, 0); chk("rst rv_dout", rv_dout, 0);
    chk("rst err", err, 0);       chk("rst ld_busy", ld_busy, 0);
    chk("rst rv_req_ack", rv_req_ack, 1);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin step(); if (m_req) seen++; end
    chk("rst no spurious m_req", seen, 0);

    // Table-driven CPU byte transactions with exact latency checks
    foreach (tbl[k]) begin
      cpu_addr = tbl[k].addr; cpu_dout = tbl[k].wdata;
      cpu_read = !tbl[k].we;  cpu_write = tbl[k].we;
      step();
      cpu_read = 1'b0; cpu_write = 1'b0;
      chk("tbl lat1 m_req", m_req, 0);
      step();
      chk("tbl lat2 m_req", m_req, 1);
      chk("tbl m_we", m_we, tbl[k].we);
      chk("tbl m_addr", m_addr, tbl[k].exp_maddr);
      chk("tbl m_ds", m_ds, tbl[k].exp_ds);
      if (tbl[k].we) chk("tbl m_din", m_din, tbl[k].exp_din);
      step(); step();
      m_ack = 1'b1; m_dout = tbl[k].mdout;
      chk("tbl done before ack", cpu_done, 0);
      step();
      m_ack = 1'b0;
      chk("tbl cpu_done", cpu_done, 1);
      if (!tbl[k].we) chk("tbl cpu_din", cpu_din, tbl[k].exp_rd);
      step();
      chk("tbl cpu_done pulse", cpu_done, 0);
    end

    // Randomized mixed traffic; first round fires all three at once
    for (int it = 0; it < 30; it++) begin
      logic [2:0] mask;
      logic [3:0] l_w, c_w, r_w;
      logic l_b, c_b, c_we, r_we;
      logic [7:0] l_d, c_d, exp_b;
      logic [1:0] r_ds;
      logic [15:0] r_d, exp_w;
      mask = (it == 0) ? 3'b111 : 3'($urandom_range(1, 7));
      l_w = 4'($urandom); l_b = 1'($urandom); l_d = 8'($urandom);
      c_w = 4'($urandom); c_b = 1'($urandom); c_d = 8'($urandom); c_we = 1'($urandom);
      r_w = 4'($urandom); r_we = 1'($urandom); r_ds = 2'($urandom); r_d = 16'($urandom);
      ld_addr = 22'({l_w, l_b}); ld_data = l_d; ld_write = mask[0];
      cpu_addr = 22'({c_w, c_b}); cpu_dout = c_d;
      cpu_read = mask[1] & !c_we; cpu_write = mask[1] & c_we;
      rv_addr = 22'(r_w); rv_we = r_we; rv_ds = r_ds; rv_din = r_d;
      if (mask[2]) rv_req = ~rv_req;
      step();
      ld_write = 1'b0; cpu_read = 1'b0; cpu_write = 1'b0;
      if (mask[0]) begin
        serve("rnd ld", 1'b1, 22'(l_w), l_b ? 2'b10 : 2'b01, {l_d, l_d}, 1'b1,
              $urandom_range(1, 5), 1'b0);
        chk("rnd ld_busy clear", ld_busy, 0);
      end
      if (mask[1]) begin
        exp_b = c_b ? mem[c_w][15:8] : mem[c_w][7:0];
        serve("rnd cpu", c_we, 22'(c_w), c_b ? 2'b10 : 2'b01, {c_d, c_d}, c_we,
              $urandom_range(1, 5), 1'b0);
        chk("rnd cpu_done", cpu_done, 1);
        if (!c_we) chk("rnd cpu_din", cpu_din, exp_b);
        step();
        chk("rnd cpu_done pulse", cpu_done, 0);
      end
      if (mask[2]) begin
        exp_w = mem[r_w];
        serve("rnd rv", r_we, 22'(r_w), r_ds, r_d, 1'b1, $urandom_range(1, 5), 1'b0);
        chk("rnd rv_req_ack", rv_req_ack, rv_req);
        if (!r_we) chk("rnd rv_dout", rv_dout, exp_w);
      end
      step();
    end

    // Starvation: CPU re-requests on every ack while an RV request waits
    begin
      int t0, r, lim;
      bit rv_seen;
      rv_seen = 1'b0;
      cpu_addr = 22'h000200;
      rv_addr = 22'h000155; rv_we = 1'b0; rv_ds = 2'b11;
      cpu_read = 1'b1; rv_req = ~rv_req; t0 = cyc;
      lim = t0 + 2 + int'(STARVE);
      step();
      cpu_read = 1'b0;
      for (int n = 0; n < 40 && !rv_seen; n++) begin
        wait_mreq("starve wait", 12, ok);
        if (!ok) break;
        r = cyc;
        if (m_addr == 22'h000155) begin
          rv_seen = 1'b1;
          chk("starve rv issue cycle", (r >= lim) && (r < lim + 4), 1);
          serve("starve rv", 1'b0, 22'h000155, 2'b11, 16'h0, 1'b0, 2, 1'b0);
          chk("starve rv ack", rv_req_ack, rv_req);
        end else begin
          chk("starve cpu before limit", r < lim, 1);
          serve("starve cpu", 1'b0, 22'h000100, 2'b01, 16'h0, 1'b0, 2, 1'b1);
          chk("starve cpu_done", cpu_done, 1);
        end
      end
      chk("starve rv issued", rv_seen, 1);
      serve("starve cpu tail", 1'b0, 22'h000100, 2'b01, 16'h0, 1'b0, 1, 1'b0);
      step();
    end

    // Loading inhibits the CPU; a second loader write while busy is dropped
    loading = 1'b1;
    cpu_addr = 22'h000030; cpu_read = 1'b1;
    ld_addr = 22'h000010; ld_data = 8'h11; ld_write = 1'b1;
    step();
    cpu_read = 1'b0;
    chk("load ld_busy", ld_busy, 1);
    ld_addr = 22'h000013; ld_data = 8'h22;
    step();
    ld_write = 1'b0;
    serve("load ld", 1'b1, 22'h000008, 2'b01, 16'h1111, 1'b1, 3, 1'b0);
    chk("load ld_busy clear", ld_busy, 0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin step(); if (m_req || cpu_done) seen++; end
    chk("load no m_req/cpu_done", seen, 0);
    loading = 1'b0;

    // Timeout on an RV read that is never acked
    begin
      logic old_ack;
      old_ack = rv_req_ack;
      rv_addr = 22'h000005; rv_we = 1'b0; rv_ds = 2'b11;
      rv_req = ~rv_req;
      step();
      wait_mreq("tmo m_req", 12, ok);
      for (int i = 0; i < int'(TMO); i++) step();
      chk("tmo err early", err, 0);
      chk("tmo ack early", rv_req_ack, old_ack);
      step();
      chk("tmo err", err, 1);
      chk("tmo rv_dout", rv_dout, 16'hFFFF);
      chk("tmo rv_req_ack", rv_req_ack, rv_req);
      old_ack = rv_req_ack;
      m_ack = 1'b1; m_dout = 16'h1234;
      step();
      m_ack = 1'b0;
      step();
      chk("stray ack ignored", rv_req_ack, old_ack);
      chk("stray ack rv_dout", rv_dout, 16'hFFFF);
      chk("err sticky", err, 1);
    end

    // Reset while in WAIT, then a late ack
    cpu_addr = 22'h000020; cpu_dout = 8'h77; cpu_write = 1'b1;
    step();
    cpu_write = 1'b0;
    wait_mreq("rstw m_req", 12, ok);
    step(); step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    m_ack = 1'b1; m_dout = 16'hBEEF;
    step();
    m_ack = 1'b0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin if (cpu_done || m_req) seen++; step(); end
    chk("rstw no done/m_req", seen, 0);
    chk("rstw m_we", m_we, 0);     chk("rstw m_addr", m_addr, 0);
    chk("rstw m_ds", m_ds, 0);     chk("rstw m_din", m_din, 0);
    chk("rstw cpu_din", cpu_din, 0); chk("rstw rv_dout", rv_dout, 0);
    chk("rstw err", err, 0);       chk("rstw ld_busy", ld_busy, 0);
    chk("rstw rv_req_ack", rv_req_ack, rv_req);
    cpu_addr = 22'h000041; cpu_read = 1'b1;
    step();
    cpu_read = 1'b0;
    chk("rstw idle lat1", m_req, 0);
    step();
    chk("rstw idle lat2", m_req, 1);
    serve("rstw cpu", 1'b0, 22'h000020, 2'b10, 16'h0, 1'b0, 1, 1'b0);
    chk("rstw cpu_done", cpu_done, 1);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 64, meaning the number of cycles a pending RV request may wait before it outranks CPU.
REQ-002 SHALL have parameter ACK_TIMEOUT, default 255, meaning the maximum number of cycles from m_req to m_ack before the transaction is aborted.
REQ-003 SHALL have port clk  in  1  system clock; the block has one clock, all logic on its rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port loading  in  1  ROM load in progress; CPU requests are inhibited while high.
REQ-006 SHALL have ports ld_write in 1 (1-cycle write strobe), ld_addr in 22 (byte address), ld_data in 8 (write byte) and ld_busy out 1 (loader buffer full).
REQ-007 SHALL have ports cpu_read in 1 and cpu_write in 1 (1-cycle strobes), cpu_addr in 22 (byte address), cpu_dout in 8 (write byte), cpu_din out 8 (read byte) and cpu_done out 1 (1-cycle completion pulse).
REQ-008 SHALL have ports rv_req in 1 (toggle request), rv_req_ack out 1 (toggle acknowledge), rv_addr in 22 (16-bit word address), rv_we in 1, rv_ds in 2 (byte enables, bit1 = upper), rv_din in 16 and rv_dout out 16.
REQ-009 SHALL have ports m_req out 1 (1-cycle pulse), m_we out 1, m_addr out 22 (word address), m_ds out 2, m_din out 16, m_ack in 1 (1-cycle completion pulse) and m_dout in 16.
REQ-010 SHALL have port err out 1, a sticky timeout flag.

Function
REQ-011 SHALL capture each requester into its own one-entry pending slot in the cycle its strobe is high, or in the cycle rv_req != rv_req_ack for RV.
REQ-012 SHALL assert ld_busy while the loader slot is full; an ld_write arriving while ld_busy is high SHALL be dropped.
REQ-013 SHALL drop a second CPU strobe that arrives while the CPU slot is full.
REQ-014 SHALL drop CPU strobes while loading=1, with no cpu_done.
REQ-015 SHALL use FSM states IDLE, ISSUE and WAIT.
REQ-016 SHALL, in IDLE, select one pending slot and go to ISSUE on the next cycle; with no slot pending it SHALL stay in IDLE.
REQ-017 SHALL use selection priority loader > CPU > RV; once RV has waited at least STARVE_LIMIT cycles, the priority SHALL be loader > RV > CPU.
REQ-018 SHALL, in ISSUE, drive m_req=1 for exactly one cycle with address, data and byte enables held stable until m_ack, then go to WAIT.
REQ-019 SHALL, for byte requesters, drive m_addr=addr[21:1], m_ds=2'b01 when addr[0]=0 and 2'b10 when addr[0]=1, and m_din={data,data}.
REQ-020 SHALL pass RV requests through unchanged: m_addr=rv_addr, m_ds=rv_ds, m_we=rv_we.
REQ-021 SHALL, in WAIT when m_ack=1, free the slot, return to IDLE, and for CPU reads latch cpu_din = addr[0] ? m_dout[15:8] : m_dout[7:0].
REQ-022 SHALL pulse cpu_done for one cycle, one cycle after the m_ack that completes a CPU transaction (read or write).
REQ-023 SHALL, one cycle after the m_ack that completes an RV transaction, latch rv_dout=m_dout on reads and toggle rv_req_ack.
REQ-024 SHALL give minimum latency from strobe to m_req of 2 cycles (capture, select, issue).
REQ-025 SHALL allow a new selection in the cycle after returning to IDLE, for back-to-back transactions.
REQ-026 SHALL, when a strobe and m_ack for the same requester occur in the same cycle, free the slot and capture the new request in that same cycle without dropping it.
REQ-027 SHALL count WAIT cycles; when the count reaches ACK_TIMEOUT it SHALL set err, complete the transaction as though acked (cpu_din=8'hFF, rv_dout=16'hFFFF), and return to IDLE.
REQ-028 SHALL saturate the RV starvation counter at STARVE_LIMIT and clear it when RV is selected.
REQ-029 SHALL ignore an m_ack received outside WAIT.
REQ-030 SHALL drive m_req only in ISSUE.

Reset
REQ-031 SHALL, while reset=1, force state IDLE, all slots empty, m_req=0, m_we=0, m_addr=0, m_ds=0, m_din=0, cpu_done=0, cpu_din=0, rv_dout=0, err=0, ld_busy=0, and all counters to 0.
REQ-032 SHALL set rv_req_ack := rv_req on reset, so that no spurious request is seen after reset.
REQ-033 SHALL, on reset during ISSUE or WAIT, abandon the transaction silently with no completion pulse or toggle, and ignore a later m_ack.

Verification
REQ-034 SHALL verify a CPU read: cpu_read with cpu_addr=22'h000101 -> m_req 2 cycles later with m_addr=22'h000080 and m_ds=2'b10; m_ack with m_dout=16'hAB12 -> cpu_din=8'hAB and cpu_done pulse one cycle later.
REQ-035 SHALL verify priority: ld_write, cpu_write and RV toggle in the same cycle -> m_req issued in the order loader, CPU, RV, each waiting for its ack.
REQ-036 SHALL verify starvation: a continuous CPU stream with RV pending -> RV issued before CPU once 64 cycles have elapsed.
REQ-037 SHALL verify timeout: an RV read with m_ack never asserted -> after 255 WAIT cycles, err=1, rv_dout=16'hFFFF and rv_req_ack toggles.
REQ-038 SHALL verify loading inhibit: loading=1 with cpu_read -> no m_req and no cpu_done; an ld_write while ld_busy=1 is dropped.
REQ-039 SHALL verify reset mid-operation: reset during WAIT, then m_ack -> no cpu_done, FSM in IDLE, all outputs at reset values.
